execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 16-bit five-stage pipeline, directly upstream of the memory stage.
- Takes ID/EX operands and controls, computes the ALU result and the branch decision, and registers them into the EX/MEM pipeline register.
- Single-cycle ALU for all ops except MUL. MUL uses an iterative shift-add unit that stalls upstream and inserts bubbles into EX/MEM while busy.

Parameters:
- WIDTH, 16, datapath width. MUL takes WIDTH iteration cycles.

Ports:
- clk  in  1  clock, all flops rising-edge.
- rst  in  1  asynchronous, active-low reset. Flops implemented locally; the existing synchronous dff/reg cells are not used.
- Rd1_IDEX  in  WIDTH  operand A.
- Rd2_IDEX  in  WIDTH  operand B / store data.
- Imm_IDEX  in  WIDTH  sign-extended immediate.
- ALUOp_IDEX  in  4  operation select.
- ALUSrc_IDEX  in  1  1: B = Imm, 0: B = Rd2.
- BrType_IDEX  in  3  branch type.
- Valid_IDEX, MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX  in  1 each  controls.
- WrR_IDEX  in  3  destination register.
- Flush_EX  in  1  squash current EX contents.
- Stall_EX  out  1  upstream must hold all *_IDEX inputs stable.
- ALUO_EXMEM, Rd2_EXMEM, Imm_EXMEM  out  WIDTH  registered result, store data, immediate.
- takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, Valid_EXMEM  out  1 each.
- WrR_EXMEM  out  3.

Behaviour:
- Operands: A = Rd1_IDEX; B = ALUSrc_IDEX ? Imm_IDEX : Rd2_IDEX. Shift amount = B[3:0].
- ALUOp results, all truncated to WIDTH:
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR.
  - 5 SLL; 6 SRL; 7 SRA; 8 ROL.
  - 9 SEQ (A==B); 10 SLT (signed A<B); 11 SLE (signed A<=B). Compare ops return 1 or 0, zero-extended.
  - 12 PASSB; 13 MUL (low WIDTH bits of A*B); 14-15 result 0.
- Branch decision, all tests on Rd1 as signed:
  - 0: none; 1 BEQZ: Rd1==0; 2 BNEZ: Rd1!=0; 3 BLTZ: Rd1<0; 4 BGEZ: Rd1>=0; 5: unconditional.
  - 6-7: not taken.
- Bubble into EX/MEM = all 1-bit outputs 0, WrR_EXMEM 0, data outputs 0.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - Valid_IDEX=1 and op!=MUL: EX/MEM captures result and controls at the next edge. Latency 1, Stall_EX=0.
  - Valid_IDEX=1 and op==MUL: Stall_EX=1 (combinational). Latch A and B, clear accumulator, count=0, go BUSY. EX/MEM gets a bubble.
  - Valid_IDEX=0: EX/MEM gets a bubble.
- BUSY:
  - Stall_EX=1; EX/MEM gets a bubble each edge.
  - Each edge: if Bm[0], acc += Am; Am <<= 1; Bm >>= 1; count++.
  - After WIDTH steps (count reaches WIDTH), go DONE.
- DONE:
  - Stall_EX=0. EX/MEM captures ALUO = acc plus the held ID/EX controls.
  - Go IDLE.
  - MUL total: Stall_EX high 1+WIDTH cycles (17 at WIDTH=16); result in EX/MEM after 18 edges.
- Flush_EX=1 has priority over everything:
  - EX/MEM loads a bubble; FSM to IDLE; count cleared; Stall_EX=0 combinationally that cycle.
  - An in-progress MUL is aborted.
- Reset (rst=0, async): every EX/MEM output 0; FSM IDLE; acc, count, Am and Bm 0; Stall_EX 0.
- Reset mid-MUL: MUL is discarded. After reset release, the next instruction starts fresh.
- Dump_IDEX passes through like any control; it is not special-cased.
- Overflow on ADD/SUB/MUL wraps silently; no flags are produced.

Test Plan:
- Reset: rst low mid-operation -> all outputs 0 and Stall_EX=0 immediately. After release, ADD Rd1=0x0003, Rd2=0x0004 -> ALUO_EXMEM=0x0007, RegWrite_EXMEM=1 one edge later.
- ALU sweep: A=0x8001, B via Imm=0x0004:
  - SLL -> 0x0010; SRL -> 0x0800; SRA -> 0xF800; ROL -> 0x0018.
  - SLT(0x8001, 0x0004) -> 0x0001.
- Branch: BrType=1 with Rd1=0 -> takeBranch_EXMEM=1. BrType=3 with Rd1=0x7FFF -> 0. BrType=5 -> 1.
- MUL: A=0x0123, B=0x0045:
  - Stall_EX high exactly 17 cycles; 17 bubbles into EX/MEM.
  - Then ALUO_EXMEM=0x4E6F with WrR and RegWrite preserved.
  - A=0xFFFF, B=0xFFFF -> 0x0001.
- Flush: Flush_EX pulsed during MUL cycle 8 -> next EX/MEM is a bubble, Stall_EX=0, FSM in IDLE. A following ADD issues normally with latency 1.
- Invalid/reserved: Valid_IDEX=0 with MemWrite_IDEX=1 -> MemWrite_EXMEM=0. ALUOp=14 -> ALUO_EXMEM=0.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU and branch resolution feeding the EX/MEM register,
// with an iterative shift-add multiplier that stalls upstream while it runs.
module execute_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Rd1_IDEX,
    input  logic [WIDTH-1:0] Rd2_IDEX,
    input  logic [WIDTH-1:0] Imm_IDEX,
    input  logic [3:0]       ALUOp_IDEX,
    input  logic             ALUSrc_IDEX,
    input  logic [2:0]       BrType_IDEX,
    input  logic             Valid_IDEX,
    input  logic             MemWrite_IDEX,
    input  logic             MemRead_IDEX,
    input  logic             MemtoReg_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic             Dump_IDEX,
    input  logic [2:0]       WrR_IDEX,
    input  logic             Flush_EX,
    output logic             Stall_EX,
    output logic [WIDTH-1:0] ALUO_EXMEM,
    output logic [WIDTH-1:0] Rd2_EXMEM,
    output logic [WIDTH-1:0] Imm_EXMEM,
    output logic             takeBranch_EXMEM,
    output logic             MemWrite_EXMEM,
    output logic             MemRead_EXMEM,
    output logic             MemtoReg_EXMEM,
    output logic             RegWrite_EXMEM,
    output logic             Dump_EXMEM,
    output logic             Valid_EXMEM,
    output logic [2:0]       WrR_EXMEM
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t               state, state_next;
    logic [WIDTH-1:0]     op_b, alu_result, acc, am, bm;
    logic [3:0]           shamt;
    logic [2*WIDTH-1:0]   rot;
    logic [CW-1:0]        count;
    logic                 branch_taken, is_mul, capture, start_mul;

    assign op_b   = ALUSrc_IDEX ? Imm_IDEX : Rd2_IDEX;
    assign shamt  = op_b[3:0];
    assign rot    = {Rd1_IDEX, Rd1_IDEX} << shamt;
    assign is_mul = (ALUOp_IDEX == 4'd13);

    always_comb begin
        alu_result = '0;
        case (ALUOp_IDEX)
            4'd0:  alu_result = Rd1_IDEX + op_b;
            4'd1:  alu_result = Rd1_IDEX - op_b;
            4'd2:  alu_result = Rd1_IDEX & op_b;
            4'd3:  alu_result = Rd1_IDEX | op_b;
            4'd4:  alu_result = Rd1_IDEX ^ op_b;
            4'd5:  alu_result = Rd1_IDEX << shamt;
            4'd6:  alu_result = Rd1_IDEX >> shamt;
            4'd7:  alu_result = $unsigned($signed(Rd1_IDEX) >>> shamt);
            4'd8:  alu_result = rot[2*WIDTH-1:WIDTH];
            4'd9:  alu_result = {{(WIDTH-1){1'b0}}, Rd1_IDEX == op_b};
            4'd10: alu_result = {{(WIDTH-1){1'b0}}, $signed(Rd1_IDEX) < $signed(op_b)};
            4'd11: alu_result = {{(WIDTH-1){1'b0}}, $signed(Rd1_IDEX) <= $signed(op_b)};
            4'd12: alu_result = op_b;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (BrType_IDEX)
            3'd1: branch_taken = (Rd1_IDEX == '0);
            3'd2: branch_taken = (Rd1_IDEX != '0);
            3'd3: branch_taken = Rd1_IDEX[WIDTH-1];
            3'd4: branch_taken = ~Rd1_IDEX[WIDTH-1];
            3'd5: branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // Stall is gated by reset so a held MUL on the inputs cannot stall during reset
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        start_mul  = 1'b0;
        Stall_EX   = 1'b0;
        if (Flush_EX) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Valid_IDEX && is_mul) begin
                        Stall_EX   = rst;
                        start_mul  = 1'b1;
                        state_next = BUSY;
                    end else if (Valid_IDEX) begin
                        capture = 1'b1;
                    end
                end
                BUSY: begin
                    Stall_EX = rst;
                    if (count == LAST_STEP) state_next = DONE;
                end
                DONE: begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            am    <= '0;
            bm    <= '0;
            count <= '0;
        end else if (Flush_EX) begin
            count <= '0;
        end else if (start_mul) begin
            acc   <= '0;
            am    <= Rd1_IDEX;
            bm    <= op_b;
            count <= '0;
        end else if (state == BUSY) begin
            if (bm[0]) acc <= acc + am;
            am    <= am << 1;
            bm    <= bm >> 1;
            count <= count + 1'b1;
        end
    end

    // Anything other than a capture (idle, multiply in flight, flush) loads a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUO_EXMEM       <= '0;
            Rd2_EXMEM        <= '0;
            Imm_EXMEM        <= '0;
            takeBranch_EXMEM <= 1'b0;
            MemWrite_EXMEM   <= 1'b0;
            MemRead_EXMEM    <= 1'b0;
            MemtoReg_EXMEM   <= 1'b0;
            RegWrite_EXMEM   <= 1'b0;
            Dump_EXMEM       <= 1'b0;
            Valid_EXMEM      <= 1'b0;
            WrR_EXMEM        <= '0;
        end else if (capture) begin
            ALUO_EXMEM       <= (state == DONE) ? acc : alu_result;
            Rd2_EXMEM        <= Rd2_IDEX;
            Imm_EXMEM        <= Imm_IDEX;
            takeBranch_EXMEM <= branch_taken;
            MemWrite_EXMEM   <= MemWrite_IDEX;
            MemRead_EXMEM    <= MemRead_IDEX;
            MemtoReg_EXMEM   <= MemtoReg_IDEX;
            RegWrite_EXMEM   <= RegWrite_IDEX;
            Dump_EXMEM       <= Dump_IDEX;
            Valid_EXMEM      <= Valid_IDEX;
            WrR_EXMEM        <= WrR_IDEX;
        end else begin
            ALUO_EXMEM       <= '0;
            Rd2_EXMEM        <= '0;
            Imm_EXMEM        <= '0;
            takeBranch_EXMEM <= 1'b0;
            MemWrite_EXMEM   <= 1'b0;
            MemRead_EXMEM    <= 1'b0;
            MemtoReg_EXMEM   <= 1'b0;
            RegWrite_EXMEM   <= 1'b0;
            Dump_EXMEM       <= 1'b0;
            Valid_EXMEM      <= 1'b0;
            WrR_EXMEM        <= '0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against a behavioural model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Rd1_IDEX, Rd2_IDEX, Imm_IDEX;
    logic [3:0]  ALUOp_IDEX;
    logic        ALUSrc_IDEX;
    logic [2:0]  BrType_IDEX;
    logic        Valid_IDEX, MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX;
    logic [2:0]  WrR_IDEX;
    logic        Flush_EX;
    logic        Stall_EX;
    logic [15:0] ALUO_EXMEM, Rd2_EXMEM, Imm_EXMEM;
    logic        takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM;
    logic        RegWrite_EXMEM, Dump_EXMEM, Valid_EXMEM;
    logic [2:0]  WrR_EXMEM;
    logic [63:0] exmem_obs;

    int errors = 0;
    int checks = 0;

    execute_stage #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX), .Imm_IDEX(Imm_IDEX),
        .ALUOp_IDEX(ALUOp_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX), .BrType_IDEX(BrType_IDEX),
        .Valid_IDEX(Valid_IDEX), .MemWrite_IDEX(MemWrite_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .MemtoReg_IDEX(MemtoReg_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .Dump_IDEX(Dump_IDEX),
        .WrR_IDEX(WrR_IDEX), .Flush_EX(Flush_EX), .Stall_EX(Stall_EX),
        .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .Imm_EXMEM(Imm_EXMEM),
        .takeBranch_EXMEM(takeBranch_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
        .MemRead_EXMEM(MemRead_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM),
        .RegWrite_EXMEM(RegWrite_EXMEM), .Dump_EXMEM(Dump_EXMEM),
        .Valid_EXMEM(Valid_EXMEM), .WrR_EXMEM(WrR_EXMEM)
    );

    always #5 clk = ~clk;

    assign exmem_obs = {6'b0, ALUO_EXMEM, Rd2_EXMEM, Imm_EXMEM, takeBranch_EXMEM,
                        MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM,
                        Dump_EXMEM, Valid_EXMEM, WrR_EXMEM};

    function automatic logic [15:0] aluRef(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p  = longint'(1) << b[3:0];
        longint r  = 0;
        case (op)
            4'd0:  r = ua + ub;
            4'd1:  r = ua - ub;
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = ua * p;
            4'd6:  r = ua / p;
            4'd7:  r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            4'd8:  r = ((ua * p) % 65536) + (ua * p) / 65536;
            4'd9:  r = (ua == ub) ? 1 : 0;
            4'd10: r = (sa < sb) ? 1 : 0;
            4'd11: r = (sa <= sb) ? 1 : 0;
            4'd12: r = ub;
            4'd13: r = ua * ub;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic logic branchRef(input logic [2:0] br, input logic [15:0] rd1);
        int s = int'($signed(rd1));
        case (br)
            3'd1: return s == 0;
            3'd2: return s != 0;
            3'd3: return s < 0;
            3'd4: return s >= 0;
            3'd5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] rd1, input logic [15:0] rd2, input logic [15:0] imm,
                                 input logic [3:0] op, input logic src, input logic [2:0] br,
                                 input logic valid, input logic [4:0] ctl, input logic [2:0] wrr);
        Rd1_IDEX = rd1; Rd2_IDEX = rd2; Imm_IDEX = imm;
        ALUOp_IDEX = op; ALUSrc_IDEX = src; BrType_IDEX = br;
        Valid_IDEX = valid;
        {MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX} = ctl;
        WrR_IDEX = wrr;
    endtask

    // Issues one instruction and checks stall behaviour and the EX/MEM contents it produces
    task automatic runInstr(input string tag, input logic [15:0] rd1, input logic [15:0] rd2,
                            input logic [15:0] imm, input logic [3:0] op, input logic src,
                            input logic [2:0] br, input logic valid, input logic [4:0] ctl,
                            input logic [2:0] wrr);
        logic [15:0] b;
        logic [63:0] expected;
        int stall_cycles;
        int bubbles;
        applyStimulus(rd1, rd2, imm, op, src, br, valid, ctl, wrr);
        #1;
        b = src ? imm : rd2;
        expected = {6'b0, aluRef(op, rd1, b), rd2, imm, branchRef(br, rd1), ctl, 1'b1, wrr};
        if (valid && op == 4'd13) begin
            stall_cycles = 0;
            bubbles = 0;
            while (Stall_EX && stall_cycles < 40) begin
                stall_cycles++;
                @(posedge clk); #1;
                if (exmem_obs == 64'd0) bubbles++;
            end
            checkOutput({tag, "_stall"}, 64'(stall_cycles), 64'd17);
            checkOutput({tag, "_bubbles"}, 64'(bubbles), 64'd17);
        end else begin
            checkOutput({tag, "_nostall"}, {63'd0, Stall_EX}, 64'd0);
            if (!valid) expected = 64'd0;
        end
        @(posedge clk); #1;
        checkOutput(tag, exmem_obs, expected);
    endtask

    initial begin
        rst = 1'b0;
        Flush_EX = 1'b0;
        applyStimulus(16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 3'd0, 1'b0, 5'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_exmem", exmem_obs, 64'd0);
        checkOutput("reset_stall", {63'd0, Stall_EX}, 64'd0);
        rst = 1'b1;

        runInstr("pre_add", 16'h1234, 16'h1111, 16'h0, 4'd0, 1'b0, 3'd2, 1'b1, 5'b00010, 3'd6);
        rst = 1'b0;
        #1;
        checkOutput("async_rst_exmem", exmem_obs, 64'd0);
        rst = 1'b1;

        applyStimulus(16'h0123, 16'h0045, 16'h0, 4'd13, 1'b0, 3'd0, 1'b1, 5'b00010, 3'd3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midmul_rst_stall", {63'd0, Stall_EX}, 64'd0);
        checkOutput("midmul_rst_exmem", exmem_obs, 64'd0);
        rst = 1'b1;
        runInstr("rst_add", 16'h0003, 16'h0004, 16'h0, 4'd0, 1'b0, 3'd0, 1'b1, 5'b00010, 3'd1);
        checkOutput("rst_add_alu", 64'(ALUO_EXMEM), 64'h0007);
        checkOutput("rst_add_regwrite", {63'd0, RegWrite_EXMEM}, 64'd1);

        runInstr("sll", 16'h8001, 16'h0, 16'h0004, 4'd5, 1'b1, 3'd0, 1'b1, 5'b00010, 3'd2);
        checkOutput("sll_val", 64'(ALUO_EXMEM), 64'h0010);
        runInstr("srl", 16'h8001, 16'h0, 16'h0004, 4'd6, 1'b1, 3'd0, 1'b1, 5'b00010, 3'd2);
        checkOutput("srl_val", 64'(ALUO_EXMEM), 64'h0800);
        runInstr("sra", 16'h8001, 16'h0, 16'h0004, 4'd7, 1'b1, 3'd0, 1'b1, 5'b00010, 3'd2);
        checkOutput("sra_val", 64'(ALUO_EXMEM), 64'hF800);
        runInstr("rol", 16'h8001, 16'h0, 16'h0004, 4'd8, 1'b1, 3'd0, 1'b1, 5'b00010, 3'd2);
        checkOutput("rol_val", 64'(ALUO_EXMEM), 64'h0018);
        runInstr("slt", 16'h8001, 16'h0, 16'h0004, 4'd10, 1'b1, 3'd0, 1'b1, 5'b00010, 3'd2);
        checkOutput("slt_val", 64'(ALUO_EXMEM), 64'h0001);

        runInstr("beqz", 16'h0000, 16'h0, 16'h0, 4'd0, 1'b0, 3'd1, 1'b1, 5'd0, 3'd0);
        checkOutput("beqz_taken", {63'd0, takeBranch_EXMEM}, 64'd1);
        runInstr("bltz", 16'h7FFF, 16'h0, 16'h0, 4'd0, 1'b0, 3'd3, 1'b1, 5'd0, 3'd0);
        checkOutput("bltz_taken", {63'd0, takeBranch_EXMEM}, 64'd0);
        runInstr("jmp", 16'h1234, 16'h0, 16'h0, 4'd0, 1'b0, 3'd5, 1'b1, 5'd0, 3'd0);
        checkOutput("jmp_taken", {63'd0, takeBranch_EXMEM}, 64'd1);

        runInstr("mul", 16'h0123, 16'h0045, 16'h0, 4'd13, 1'b0, 3'd0, 1'b1, 5'b00010, 3'd5);
        checkOutput("mul_val", 64'(ALUO_EXMEM), 64'h4E6F);
        checkOutput("mul_wrr", 64'(WrR_EXMEM), 64'd5);
        runInstr("mul_ff", 16'hFFFF, 16'hFFFF, 16'h0, 4'd13, 1'b0, 3'd0, 1'b1, 5'b00010, 3'd7);
        checkOutput("mul_ff_val", 64'(ALUO_EXMEM), 64'h0001);

        applyStimulus(16'h0123, 16'h0045, 16'h0, 4'd13, 1'b0, 3'd0, 1'b1, 5'b00010, 3'd3);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            checkOutput("flush_busy_stall", {63'd0, Stall_EX}, 64'd1);
        end
        Flush_EX = 1'b1;
        #1;
        checkOutput("flush_stall", {63'd0, Stall_EX}, 64'd0);
        @(posedge clk); #1;
        checkOutput("flush_bubble", exmem_obs, 64'd0);
        Flush_EX = 1'b0;
        runInstr("flush_add", 16'h0010, 16'h0020, 16'h0, 4'd0, 1'b0, 3'd0, 1'b1, 5'b00010, 3'd4);

        runInstr("invalid_sw", 16'h0001, 16'h0002, 16'h0, 4'd0, 1'b0, 3'd5, 1'b0, 5'b10000, 3'd1);
        checkOutput("invalid_memwrite", {63'd0, MemWrite_EXMEM}, 64'd0);
        runInstr("op14", 16'h5555, 16'h3333, 16'h0, 4'd14, 1'b0, 3'd0, 1'b1, 5'b00010, 3'd1);
        checkOutput("op14_val", 64'(ALUO_EXMEM), 64'd0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd13 && $urandom_range(0, 3) != 0) op = 4'd0;
            runInstr("rand", 16'($urandom), 16'($urandom), 16'($urandom), op,
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 3) != 0), 5'($urandom), 3'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
